regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_dbg_seq.sv | 111 +++++++++++
 rtl/regfile_mp.sv | 95 +++++++++
 tb/tb_regfile_mp.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// Holds the sequencer state enum, default widths and the depth helper.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DUMP
  } state_e;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/regfile_dbg_seq.sv
// Clear/dump sequencer: FSM, shared pointer and registered dbg_* beat.
// Ports: clr_req/dbg_start pulses in, clr write port and dump read
// address out to storage, dump_rdata back, dbg valid/ready stream, busy.
module regfile_dbg_seq
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  input  logic              dbg_start,
  input  logic              dbg_ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic [ADDR_W-1:0] dump_raddr,
  input  logic [DATA_W-1:0] dump_rdata,
  output logic              dbg_valid,
  output logic [ADDR_W-1:0] dbg_idx,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_last,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] ptr_nxt;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  assign ptr_nxt = ptr_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    valid_d    = valid_q;
    idx_d      = idx_q;
    data_d     = data_q;
    last_d     = last_q;
    clr_we     = 1'b0;
    clr_addr   = ptr_q;
    dump_raddr = ptr_nxt;
    unique case (state_q)
      ST_IDLE: begin
        dump_raddr = '0;
        // clear has priority over a simultaneous dump request
        if (clr_req) begin
          state_d = ST_CLEAR;
          ptr_d   = ADDR_W'(1);
        end else if (dbg_start) begin
          state_d = ST_DUMP;
          ptr_d   = '0;
          valid_d = 1'b1;
          idx_d   = '0;
          data_d  = dump_rdata;
          last_d  = 1'b0;
        end
      end
      ST_CLEAR: begin
        clr_we = 1'b1;
        ptr_d  = ptr_nxt;
        if (ptr_q == LAST) state_d = ST_IDLE;
      end
      ST_DUMP: begin
        if (valid_q && dbg_ready) begin
          if (last_q) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            ptr_d  = ptr_nxt;
            idx_d  = ptr_nxt;
            data_d = dump_rdata;
            last_d = (ptr_nxt == LAST);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign dbg_valid = valid_q;
  assign dbg_idx   = idx_q;
  assign dbg_data  = data_q;
  assign dbg_last  = last_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file, entry 0 hardwired to zero, with clear
// engine and dbg valid/ready dump stream. Ports: packed raddr/rdata
// (NUM_RD ports), we/waddr/wdata, clr_req, dbg_* stream, busy.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read bypass on
// read ports and dump beat load.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     clr_req,
  input  logic                     dbg_start,
  output logic                     dbg_valid,
  input  logic                     dbg_ready,
  output logic [ADDR_W-1:0]        dbg_idx,
  output logic [DATA_W-1:0]        dbg_data,
  output logic                     dbg_last,
  output logic                     busy
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] dump_raddr;
  logic [DATA_W-1:0] dump_rdata;

  regfile_dbg_seq #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_req   (clr_req),
    .dbg_start (dbg_start),
    .dbg_ready (dbg_ready),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .dump_raddr(dump_raddr),
    .dump_rdata(dump_rdata),
    .dbg_valid (dbg_valid),
    .dbg_idx   (dbg_idx),
    .dbg_data  (dbg_data),
    .dbg_last  (dbg_last),
    .busy      (busy)
  );

  // external write is applied last so it beats the clear engine
  always_comb begin
    mem_d = mem_q;
    if (clr_we) mem_d[clr_addr] = '0;
    if (we) mem_d[waddr] = wdata;
    mem_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] rd;
    assign a = raddr[k*ADDR_W +: ADDR_W];
    always_comb begin
      rd = mem_q[a];
`ifdef REGFILE_BYPASS_EN
      if (we && (waddr == a) && (waddr != '0)) rd = wdata;
`endif
    end
    assign rdata[k*DATA_W +: DATA_W] = rd;
  end

  always_comb begin
    dump_rdata = mem_q[dump_raddr];
`ifdef REGFILE_BYPASS_EN
    if (we && (waddr == dump_raddr) && (waddr != '0)) dump_rdata = wdata;
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed plan plus random traffic
// compared every cycle against a behavioural model of the register file.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic clr_req, dbg_start, dbg_valid, dbg_ready, dbg_last, busy;
  logic [AW-1:0] dbg_idx;
  logic [DW-1:0] dbg_data;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .clr_req(clr_req), .dbg_start(dbg_start),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
    .dbg_idx(dbg_idx), .dbg_data(dbg_data),
    .dbg_last(dbg_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: memory array, mode (0 idle, 1 clear, 2 dump)
  logic [DW-1:0] mm [DEPTH];
  logic [DW-1:0] mm_n [DEPTH];
  int mode, mp;
  logic e_valid;
  logic [AW-1:0] e_idx;
  logic [DW-1:0] e_data;

  function automatic logic [DW-1:0] m_read(input int a);
    if (a == 0) return '0;
    if (BYP && we && (int'(waddr) == a)) return wdata;
    return mm[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mm[i] = '0;
      mode = 0; mp = 0;
      e_valid = 1'b0; e_idx = '0; e_data = '0;
    end else begin
      mm_n = mm;
      if (mode == 1) mm_n[mp] = '0;
      if (we && waddr != 0) mm_n[waddr] = wdata;
      case (mode)
        0: begin
          if (clr_req) begin
            mode = 1; mp = 1;
          end else if (dbg_start) begin
            mode = 2; e_valid = 1'b1; e_idx = '0; e_data = m_read(0);
          end
        end
        1: begin
          if (mp == DEPTH - 1) mode = 0;
          else mp++;
        end
        default: begin
          if (e_valid && dbg_ready) begin
            if (int'(e_idx) == DEPTH - 1) begin
              mode = 0; e_valid = 1'b0;
            end else begin
              e_idx = e_idx + 1'b1;
              e_data = m_read(int'(e_idx));
            end
          end
        end
      endcase
      mm = mm_n;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NR; k++)
        chk("rdata", rdata[k*DW +: DW], m_read(int'(raddr[k*AW +: AW])));
      chk("busy", busy, mode != 0);
      chk("dbg_valid", dbg_valid, e_valid);
      if (e_valid) begin
        chk("dbg_idx", dbg_idx, e_idx);
        chk("dbg_data", dbg_data, e_data);
        chk("dbg_last", dbg_last, int'(e_idx) == DEPTH - 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    we = 1'b0; clr_req = 1'b0; dbg_start = 1'b0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    we = 1'b1; waddr = AW'(a); wdata = d;
    tick();
  endtask

  task automatic rd2(input int a0, input int a1);
    raddr = {AW'(a1), AW'(a0)};
    #1;
  endtask

  int cnt, beats, cyc;
  bit stalled, sawv;

  initial begin
    we = 0; waddr = 0; wdata = 0; raddr = 0;
    clr_req = 0; dbg_start = 0; dbg_ready = 0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_valid", dbg_valid, 0);
    chk("rst_last", dbg_last, 0);
    chk("rst_idx", dbg_idx, 0);
    chk("rst_data", dbg_data, 0);
    chk("rst_rdata", rdata, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    wr(5, 32'hDEADBEEF);
    rd2(5, 5);
    chk("r5_p0", rdata[31:0], 32'hDEADBEEF);
    chk("r5_p1", rdata[63:32], 32'hDEADBEEF);
    wr(0, 32'h1234);
    rd2(0, 5);
    chk("r0_zero", rdata[31:0], 0);

    we = 1'b1; waddr = 7; wdata = 32'hA5A5A5A5;
    rd2(7, 0);
    chk("bypass_r7", rdata[31:0], BYP ? 32'hA5A5A5A5 : 32'h0);
    tick();
    rd2(7, 7);
    chk("r7_after", rdata[63:32], 32'hA5A5A5A5);

    for (int i = 1; i < DEPTH; i++) wr(i, DW'(i));
    rd2(0, 0);
    clr_req = 1'b1;
    tick();
    cnt = 0;
    while (busy && cnt < 100) begin
      if (cnt == 2) begin we = 1; waddr = 20; wdata = 32'h55; end
      if (cnt == 3) begin we = 1; waddr = 2; wdata = 32'h66; end
      tick();
      cnt++;
    end
    chk("clear_cycles", cnt, 31);
    rd2(20, 2);
    chk("clr_r20", rdata[31:0], 0);
    chk("clr_r2", rdata[63:32], 32'h66);
    rd2(1, 31);
    chk("clr_r1", rdata[31:0], 0);
    chk("clr_r31", rdata[63:32], 0);

    for (int i = 1; i < DEPTH; i++) wr(i, DW'(i * 3));
    dbg_ready = 1'b1; dbg_start = 1'b1;
    tick();
    beats = 0; stalled = 0; cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      if (dbg_valid && dbg_idx == 10 && !stalled) begin
        stalled = 1; dbg_ready = 1'b0;
        we = 1; waddr = 10; wdata = 32'hFFFF;
        for (int s = 0; s < 5; s++) begin
          tick();
          chk("stall_valid", dbg_valid, 1);
          chk("stall_idx", dbg_idx, 10);
          chk("stall_data", dbg_data, 30);
        end
        dbg_ready = 1'b1;
      end
      if (dbg_valid && dbg_ready) begin
        chk("beat_idx", dbg_idx, beats);
        chk("beat_data", dbg_data, beats * 3);
        chk("beat_last", dbg_last, beats == 31);
        beats++;
      end
      tick();
    end
    chk("beats", beats, 32);
    chk("dump_busy", busy, 0);
    chk("dump_valid", dbg_valid, 0);

    dbg_start = 1'b1;
    tick();
    cyc = 0;
    while (!(dbg_valid && dbg_idx == 12) && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("reach_idx12", dbg_idx, 12);
    rd2(13, 5);
    rst_n = 1'b0;
    #1;
    chk("rstm_valid", dbg_valid, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_data", dbg_data, 0);
    chk("rstm_r13", rdata[31:0], 0);
    chk("rstm_r5", rdata[63:32], 0);
    tick();
    rst_n = 1'b1;

    wr(3, 32'h9);
    clr_req = 1'b1; dbg_start = 1'b1;
    tick();
    cnt = 0; sawv = 0;
    while (busy && cnt < 100) begin
      if (dbg_valid) sawv = 1;
      tick();
      cnt++;
    end
    chk("both_clear_cycles", cnt, 31);
    chk("both_no_dump", sawv, 0);
    rd2(3, 0);
    chk("both_r3", rdata[31:0], 0);

    repeat (3000) begin
      we = 1'($urandom);
      waddr = AW'($urandom);
      wdata = $urandom;
      raddr = (NR*AW)'($urandom);
      dbg_ready = ($urandom_range(0, 3) != 0);
      clr_req = ($urandom_range(0, 60) == 0);
      dbg_start = ($urandom_range(0, 30) == 0);
      @(posedge clk);
      #2;
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
